// File: rtl/lut_cfg_sequencer.sv
// Serialises a parallel config word into an 8-entry shift-register LUT (MSB first)
// and services single-outstanding addressed lookups; lookups stall during reloads.
module lut_cfg_sequencer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DEPTH-1:0]  cfg_data,
   input  logic              lk_valid,
   output logic              lk_ready,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              rsp_valid,
   output logic              rsp_data,
   output logic              sr_en,
   output logic              sr_bit,
   output logic [ADDR_W-1:0] sr_addr,
   input  logic              sr_z,
   output logic              configured,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [DEPTH-1:0]  word, word_nxt;
   logic              done, done_nxt;
   logic              inflight, inflight_nxt;
   logic              cfg_ready_nxt, lk_ready_nxt, rsp_valid_nxt, rsp_data_nxt;
   logic              sr_en_nxt, sr_bit_nxt, configured_nxt, busy_nxt;
   logic [ADDR_W-1:0] sr_addr_nxt;
   logic              lk_acc, cfg_acc;

   // A lookup offered alongside a config word always wins the cycle.
   assign lk_acc  = lk_valid && lk_ready;
   assign cfg_acc = cfg_valid && cfg_ready && !lk_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         word       <= '0;
         done       <= 1'b0;
         inflight   <= 1'b0;
         cfg_ready  <= 1'b0;
         lk_ready   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 1'b0;
         sr_en      <= 1'b0;
         sr_bit     <= 1'b0;
         sr_addr    <= '0;
         configured <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         word       <= word_nxt;
         done       <= done_nxt;
         inflight   <= inflight_nxt;
         cfg_ready  <= cfg_ready_nxt;
         lk_ready   <= lk_ready_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_data   <= rsp_data_nxt;
         sr_en      <= sr_en_nxt;
         sr_bit     <= sr_bit_nxt;
         sr_addr    <= sr_addr_nxt;
         configured <= configured_nxt;
         busy       <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      word_nxt       = word;
      done_nxt       = done;
      inflight_nxt   = inflight;
      cfg_ready_nxt  = cfg_ready;
      lk_ready_nxt   = lk_ready;
      rsp_valid_nxt  = 1'b0;
      rsp_data_nxt   = rsp_data;
      sr_en_nxt      = 1'b0;
      sr_bit_nxt     = sr_bit;
      sr_addr_nxt    = sr_addr;
      configured_nxt = configured;
      busy_nxt       = busy;

      case (state)
         IDLE: begin
            cfg_ready_nxt = 1'b1;
            lk_ready_nxt  = 1'b0;
            if (cfg_acc) begin
               word_nxt      = cfg_data;
               cnt_nxt       = ADDR_W'(DEPTH - 1);
               done_nxt      = 1'b0;
               state_nxt     = LOAD;
               cfg_ready_nxt = 1'b0;
            end
         end
         LOAD: begin
            cfg_ready_nxt = 1'b0;
            lk_ready_nxt  = 1'b0;
            if (!done) begin
               sr_en_nxt  = 1'b1;
               busy_nxt   = 1'b1;
               sr_bit_nxt = word[cnt];
               if (cnt == '0) done_nxt = 1'b1;
               else           cnt_nxt  = cnt - ADDR_W'(1);
            end else begin
               // All bits shifted: the LUT is coherent from here on.
               busy_nxt       = 1'b0;
               configured_nxt = 1'b1;
               done_nxt       = 1'b0;
               state_nxt      = READY;
               lk_ready_nxt   = 1'b1;
               cfg_ready_nxt  = !lk_valid;
            end
         end
         READY: begin
            if (lk_acc) begin
               sr_addr_nxt   = lk_addr;
               inflight_nxt  = 1'b1;
               lk_ready_nxt  = 1'b0;
               cfg_ready_nxt = 1'b0;
            end else if (inflight) begin
               // sr_z has settled on the address registered last cycle.
               rsp_valid_nxt = 1'b1;
               rsp_data_nxt  = sr_z;
               inflight_nxt  = 1'b0;
               lk_ready_nxt  = 1'b1;
               cfg_ready_nxt = !lk_valid;
            end else if (cfg_acc) begin
               word_nxt      = cfg_data;
               cnt_nxt       = ADDR_W'(DEPTH - 1);
               done_nxt      = 1'b0;
               state_nxt     = LOAD;
               cfg_ready_nxt = 1'b0;
               lk_ready_nxt  = 1'b0;
            end else begin
               lk_ready_nxt  = 1'b1;
               cfg_ready_nxt = !lk_valid;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lut_cfg_sequencer.sv
// Directed bench: models the LUT shift register and checks load order, lookup
// timing, lookup/config priority and reset behaviour mid-load and mid-lookup.
module tb_lut_cfg_sequencer;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [DEPTH-1:0]  cfg_data = '0;
   logic              lk_valid = 1'b0;
   logic              lk_ready;
   logic [ADDR_W-1:0] lk_addr = '0;
   logic              rsp_valid, rsp_data, sr_en, sr_bit, sr_z, configured, busy;
   logic [ADDR_W-1:0] sr_addr;
   logic [DEPTH-1:0]  lut = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lut_cfg_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .sr_en(sr_en), .sr_bit(sr_bit), .sr_addr(sr_addr), .sr_z(sr_z),
      .configured(configured), .busy(busy)
   );

   // Behavioural LUT: serial bit enters at bit 0 and moves toward bit DEPTH-1.
   always @(posedge clk) if (sr_en) lut <= {lut[DEPTH-2:0], sr_bit};
   assign sr_z = lut[sr_addr];

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              exp;
   } lk_vec_t;

   lk_vec_t vec[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_cfg_ready();
      int n = 0;
      while (cfg_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cfg_ready_wait", 32'(cfg_ready), 1);
   endtask

   task automatic wait_lk_ready();
      int n = 0;
      while (lk_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("lk_ready_wait", 32'(lk_ready), 1);
   endtask

   task automatic present_cfg(input logic [DEPTH-1:0] data);
      wait_cfg_ready();
      cfg_data  = data;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Called in the cycle right after the accept edge.
   task automatic observe_load(input logic [DEPTH-1:0] data, input logic cfg_during);
      logic [DEPTH-1:0] seq = '0;
      int shifts = 0, rdy_hi = 0, busy_lo = 0, cfgd_bad = 0;
      chk("load_pre_shift_sr_en", 32'(sr_en), 0);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         if (sr_en) begin
            shifts++;
            seq = {seq[DEPTH-2:0], sr_bit};
         end
         if (lk_ready || cfg_ready) rdy_hi++;
         if (!busy) busy_lo++;
         if (configured !== cfg_during) cfgd_bad++;
      end
      chk("load_shift_count", 32'(shifts), DEPTH);
      chk("load_bit_order", 32'(seq), 32'(data));
      chk("load_ready_high", 32'(rdy_hi), 0);
      chk("load_busy_low", 32'(busy_lo), 0);
      chk("load_configured_during", 32'(cfgd_bad), 0);
      @(negedge clk);
      chk("load_end", 32'({sr_en, busy, configured}), 32'(3'b001));
      chk("lut_contents", 32'(lut), 32'(data));
   endtask

   task automatic do_lookup(input logic [ADDR_W-1:0] addr, input logic exp);
      wait_lk_ready();
      lk_addr  = addr;
      lk_valid = 1'b1;
      @(negedge clk);
      lk_valid = 1'b0;
      chk("lk_ready_after_accept", 32'(lk_ready), 0);
      chk("rsp_early", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_data", 32'(rsp_data), 32'(exp));
   endtask

   initial begin
      int cnt;
      // LUT holding 8'hA5, read at addresses 0..7.
      vec[0] = '{3'd0, 1'b1}; vec[1] = '{3'd1, 1'b0};
      vec[2] = '{3'd2, 1'b1}; vec[3] = '{3'd3, 1'b0};
      vec[4] = '{3'd4, 1'b0}; vec[5] = '{3'd5, 1'b1};
      vec[6] = '{3'd6, 1'b0}; vec[7] = '{3'd7, 1'b1};

      // Reset values
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs",
          32'({cfg_ready, lk_ready, rsp_valid, rsp_data, sr_en, sr_bit, sr_addr, configured, busy}), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_cfg_ready", 32'(cfg_ready), 1);
      chk("idle_lk_ready", 32'(lk_ready), 0);

      // Test 1: load A5
      present_cfg(8'hA5);
      observe_load(8'hA5, 1'b0);

      // Test 2: back-to-back lookups from the table
      for (int i = 0; i < 8; i++) begin
         chk("lk_ready_toggle", 32'(lk_ready), 1);
         do_lookup(vec[i].addr, vec[i].exp);
      end
      @(negedge clk);
      chk("rsp_single_pulse", 32'(rsp_valid), 0);

      // Test 3: lookup before any configuration stalls
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lk_addr  = 3'd3;
      lk_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (lk_ready || rsp_valid) cnt++;
      end
      chk("unconfigured_lookup_stall", 32'(cnt), 0);
      present_cfg(8'h08);
      observe_load(8'h08, 1'b0);
      do_lookup(3'd3, 1'b1);

      // Test 4: simultaneous cfg and lookup; lookup wins
      chk("both_ready", 32'({cfg_ready, lk_ready}), 32'(2'b11));
      cfg_data  = 8'hFF;
      cfg_valid = 1'b1;
      lk_addr   = 3'd0;
      lk_valid  = 1'b1;
      @(negedge clk);
      lk_valid = 1'b0;
      chk("prio_after_accept", 32'({lk_ready, cfg_ready, sr_en}), 0);
      @(negedge clk);
      chk("prio_rsp", 32'({rsp_valid, rsp_data}), 32'(2'b10));
      chk("prio_cfg_ready", 32'(cfg_ready), 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      observe_load(8'hFF, 1'b1);
      do_lookup(3'd0, 1'b1);

      // Test 5: reset on the 4th shift cycle
      present_cfg(8'h3C);
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("mid_load_shifting", 32'(sr_en), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_load_reset", 32'({sr_en, busy, configured, cfg_ready, lk_ready}), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_cfg_ready", 32'(cfg_ready), 1);
      present_cfg(8'hC3);
      observe_load(8'hC3, 1'b0);

      // Test 6: reset with a lookup in flight
      wait_lk_ready();
      lk_addr  = 3'd5;
      lk_valid = 1'b1;
      @(negedge clk);
      lk_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      if (rsp_valid) cnt++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("dropped_response", 32'(cnt), 0);
      present_cfg(8'h01);
      observe_load(8'h01, 1'b0);
      do_lookup(3'd0, 1'b1);
      do_lookup(3'd7, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
